// File: rtl/dino_pkg.sv
// Shared types for the Dino score keeper: game state and packed BCD digits.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_e;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] bcd4_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter with clear, increment and a 9->0 carry-out.
module bcd_digit_counter
  import dino_pkg::*;
(
  input  logic clk_1k_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t digit_o,
  output logic carry_o
);

  bcd_t digit_q, digit_d;

  assign carry_o = inc_i && (digit_q == 4'd9);
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (inc_i) begin
      digit_d = carry_o ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_1k_i) begin
    if (!rst_ni) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/dino_score_counter.sv
// Dino run score keeper: BCD score, high score, and registered display digits
// with leading-zero blanking and game-over blink.
module dino_score_counter
  import dino_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = 100,
  parameter int unsigned BLINK_TICKS     = 250
) (
  input  logic        clk_1k_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        collision_i,
  output logic [1:0]  state_o,
  output logic [15:0] score_o,
  output logic [15:0] hiscore_o,
  output logic        digit0_en_o,
  output logic [3:0]  digit0_o,
  output logic        digit1_en_o,
  output logic [3:0]  digit1_o,
  output logic        digit2_en_o,
  output logic [3:0]  digit2_o,
  output logic        digit3_en_o,
  output logic [3:0]  digit3_o
);

  game_state_e state_q, state_d;
  logic [9:0]  presc_q, presc_d;
  logic [9:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  bcd4_t       hiscore_q, hiscore_d;
  bcd4_t       disp_q, disp_d;
  logic [3:0]  en_q, en_d;

  bcd4_t       score;
  logic [3:0]  carry;
  logic        score_clr, score_inc;
  logic        presc_wrap, sat;
  bcd4_t       src;
  logic [3:0]  lit;

  assign presc_wrap = (presc_q == 10'(TICKS_PER_POINT - 1));
  assign sat        = (score == 16'h9999);

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk_1k_i (clk_1k_i),
      .rst_ni   (rst_ni),
      .clr_i    (score_clr),
      .inc_i    ((i == 0) ? score_inc : carry[(i == 0) ? 0 : i - 1]),
      .digit_o  (score[i]),
      .carry_o  (carry[i])
    );
  end

  // Saturation is caught before the chain, so the top carry never fires.
  logic unused_carry;
  assign unused_carry = carry[3];

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    hiscore_d   = hiscore_q;
    score_clr   = 1'b0;
    score_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          score_clr = 1'b1;
          presc_d   = '0;
        end
      end
      RUN: begin
        presc_d = presc_wrap ? 10'd0 : presc_q + 10'd1;
        // A collision on the wrap cycle suppresses that cycle's point.
        if (collision_i) begin
          state_d = OVER;
          if (score > hiscore_q) hiscore_d = score;
        end else if (presc_wrap && !sat) begin
          score_inc = 1'b1;
        end
      end
      OVER: begin
        if (start_i) begin
          state_d   = RUN;
          score_clr = 1'b1;
          presc_d   = '0;
        end else if (blink_cnt_q == 10'(BLINK_TICKS - 1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 10'd1;
          blink_on_d  = blink_on_q;
        end
      end
      default: state_d = IDLE;
    endcase

    src    = (state_q == IDLE) ? hiscore_q : score;
    lit[3] = (src[3] != 4'd0);
    lit[2] = lit[3] | (src[2] != 4'd0);
    lit[1] = lit[2] | (src[1] != 4'd0);
    lit[0] = 1'b1;
    disp_d = src;
    en_d   = lit & {4{blink_on_q}};
  end

  always_ff @(posedge clk_1k_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hiscore_q   <= '0;
      disp_q      <= '0;
      en_q        <= 4'b0001;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hiscore_q   <= hiscore_d;
      disp_q      <= disp_d;
      en_q        <= en_d;
    end
  end

  assign state_o     = state_q;
  assign score_o     = score;
  assign hiscore_o   = hiscore_q;
  assign digit0_o    = disp_q[0];
  assign digit1_o    = disp_q[1];
  assign digit2_o    = disp_q[2];
  assign digit3_o    = disp_q[3];
  assign digit0_en_o = en_q[0];
  assign digit1_en_o = en_q[1];
  assign digit2_en_o = en_q[2];
  assign digit3_en_o = en_q[3];

endmodule

// File: tb/tb_dino_score_counter.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor
// compares them after the matching clock edge.
module tb_dino_score_counter;

  localparam int SigState = 0;
  localparam int SigScore = 1;
  localparam int SigHi    = 2;
  localparam int SigEn    = 3;
  localparam int SigDig   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        collision;
  logic [1:0]  state;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        en0, en1, en2, en3;
  logic [3:0]  d0, d1, d2, d3;

  dino_score_counter #(
    .TICKS_PER_POINT (2),
    .BLINK_TICKS     (3)
  ) dut (
    .clk_1k_i    (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .collision_i (collision),
    .state_o     (state),
    .score_o     (score),
    .hiscore_o   (hiscore),
    .digit0_en_o (en0),
    .digit0_o    (d0),
    .digit1_en_o (en1),
    .digit1_o    (d1),
    .digit2_en_o (en2),
    .digit2_o    (d2),
    .digit3_en_o (en3),
    .digit3_o    (d3)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] pick(int sig);
    case (sig)
      SigState: return {14'd0, state};
      SigScore: return score;
      SigHi:    return hiscore;
      SigEn:    return {12'd0, en3, en2, en1, en0};
      default:  return {d3, d2, d1, d0};
    endcase
  endfunction

  task automatic expect_at(input int ahead, input int sig, input logic [15:0] val,
                           input string name);
    exp_t e;
    e.cyc  = cyc + ahead;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_collision();
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
  endtask

  // Monitor: samples shortly after each rising edge.
  initial forever begin
    logic [15:0] act;
    @(posedge clk);
    cyc++;
    #2;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        act = pick(q[i].sig);
        if (act !== q[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d: got %h expected %h", q[i].name, cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    int c;
    rst_n     = 1'b0;
    start     = 1'b0;
    collision = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset and idle
    expect_at(5, SigState, 16'h0000, "idle_state");
    expect_at(5, SigEn,    16'h0001, "idle_en");
    expect_at(5, SigDig,   16'h0000, "idle_digits");
    expect_at(5, SigHi,    16'h0000, "idle_hiscore");
    expect_at(5, SigScore, 16'h0000, "idle_score");
    wait_until(cyc + 5);

    // Game A: carry into tens, collide at 0x0042 on a wrap cycle, then blink
    c = cyc;
    expect_at(1,  SigState, 16'h0001, "a_run");
    expect_at(19, SigScore, 16'h0009, "a_score9");
    expect_at(21, SigScore, 16'h0010, "a_score10");
    expect_at(21, SigEn,    16'h0001, "a_en_lag");
    expect_at(22, SigEn,    16'h0003, "a_en10");
    expect_at(22, SigDig,   16'h0010, "a_dig10");
    expect_at(85, SigScore, 16'h0042, "a_score42");
    expect_at(86, SigHi,    16'h0000, "a_hi_before");
    expect_at(87, SigState, 16'h0002, "a_over");
    expect_at(87, SigScore, 16'h0042, "a_coll_wins");
    expect_at(87, SigHi,    16'h0042, "a_hi42");
    expect_at(89, SigScore, 16'h0042, "a_over_hold");
    expect_at(90, SigEn,    16'h0003, "a_blink_on0");
    expect_at(91, SigEn,    16'h0000, "a_blink_off0");
    expect_at(91, SigDig,   16'h0042, "a_blink_dig");
    expect_at(93, SigEn,    16'h0000, "a_blink_off1");
    expect_at(94, SigEn,    16'h0003, "a_blink_on1");
    expect_at(96, SigEn,    16'h0003, "a_blink_on2");
    expect_at(97, SigEn,    16'h0000, "a_blink_off2");
    pulse_start();
    wait_until(c + 86);
    pulse_collision();
    wait_until(c + 98);

    // Game B: restart from OVER, start ignored in RUN, lower score keeps hiscore
    c = cyc;
    expect_at(1,  SigState, 16'h0001, "b_run");
    expect_at(1,  SigScore, 16'h0000, "b_clear");
    expect_at(2,  SigEn,    16'h0001, "b_en_solid0");
    expect_at(2,  SigDig,   16'h0000, "b_dig0");
    expect_at(5,  SigEn,    16'h0001, "b_en_solid1");
    expect_at(7,  SigEn,    16'h0001, "b_en_solid2");
    expect_at(13, SigScore, 16'h0006, "b_start_ignored");
    expect_at(13, SigState, 16'h0001, "b_still_run");
    expect_at(35, SigScore, 16'h0017, "b_score17");
    expect_at(37, SigState, 16'h0002, "b_over");
    expect_at(37, SigScore, 16'h0017, "b_score_hold");
    expect_at(37, SigHi,    16'h0042, "b_hi_kept");
    pulse_start();
    wait_until(c + 10);
    pulse_start();
    wait_until(c + 36);
    pulse_collision();
    wait_until(c + 40);

    // Game C: raise hiscore to 0x0050
    c = cyc;
    expect_at(101, SigScore, 16'h0050, "c_score50");
    expect_at(102, SigState, 16'h0002, "c_over");
    expect_at(102, SigHi,    16'h0050, "c_hi50");
    pulse_start();
    wait_until(c + 101);
    pulse_collision();
    wait_until(c + 105);

    // Game D: reset in RUN at 0x0123
    c = cyc;
    expect_at(247, SigScore, 16'h0123, "d_score123");
    expect_at(247, SigHi,    16'h0050, "d_hi50");
    expect_at(248, SigState, 16'h0000, "d_rst_state");
    expect_at(248, SigScore, 16'h0000, "d_rst_score");
    expect_at(248, SigHi,    16'h0000, "d_rst_hi");
    expect_at(248, SigEn,    16'h0001, "d_rst_en");
    expect_at(248, SigDig,   16'h0000, "d_rst_dig");
    pulse_start();
    wait_until(c + 247);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(c + 250);

    // Game E: hundreds, thousands, saturation at 9999
    c = cyc;
    expect_at(201,   SigScore, 16'h0100, "e_score100");
    expect_at(202,   SigEn,    16'h0007, "e_en100");
    expect_at(202,   SigDig,   16'h0100, "e_dig100");
    expect_at(2001,  SigScore, 16'h1000, "e_score1000");
    expect_at(2002,  SigEn,    16'h000f, "e_en1000");
    expect_at(19997, SigScore, 16'h9998, "e_score9998");
    expect_at(19999, SigScore, 16'h9999, "e_score9999");
    expect_at(20011, SigScore, 16'h9999, "e_sat_hold");
    expect_at(20012, SigDig,   16'h9999, "e_sat_dig");
    expect_at(20012, SigEn,    16'h000f, "e_sat_en");
    pulse_start();
    wait_until(c + 20015);

    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL e_final_state: got %h expected 1", state);
    end
    checks++;
    if (score !== 16'h9999) begin
      errors++;
      $display("FAIL e_final_score: got %h expected 9999", score);
    end
    checks++;
    if (hiscore !== 16'h0000) begin
      errors++;
      $display("FAIL e_final_hi: got %h expected 0000", hiscore);
    end
    checks++;
    if ({en3, en2, en1, en0} !== 4'hf) begin
      errors++;
      $display("FAIL e_final_en: got %b expected 1111", {en3, en2, en1, en0});
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h9999) begin
      errors++;
      $display("FAIL e_final_dig: got %h expected 9999", {d3, d2, d1, d0});
    end

    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never compared: expected %h at cyc %0d", q[i].name, q[i].val, q[i].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
